xbar_sched: RTL

- Scheduler for the 4-input/4-output FIFO crossbar datapath: input FIFOs 0-3 feed output FIFOs 4-7.
- Each input FIFO head word carries its destination in bits [9:8].
- Picks one input FIFO per grant with a round-robin pointer and drives the datapath select `demux0`.
- Issues the pop strobe to the granted input FIFO and the push strobe to the destination output FIFO.
- Moves a burst of up to MAX_BURST words per grant.
- All FIFOs are first-word-fall-through: head data is valid whenever the FIFO is not empty.

---
 rtl/xbar_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/xbar_sched.sv
// rtl/xbar_sched.sv - burst scheduler for the 4x4 FIFO crossbar (input FIFOs 0-3 to output FIFOs 4-7)
// Optional XBAR_SCHED_STRICT_PRIO_EN: fixed priority with input 0 highest, no round-robin pointer.
module xbar_sched #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] in_empty,
  input  logic [3:0] out_full,
  input  logic [1:0] head_dest0,
  input  logic [1:0] head_dest1,
  input  logic [1:0] head_dest2,
  input  logic [1:0] head_dest3,
  output logic [1:0] demux0,
  output logic [3:0] pop,
  output logic [3:0] push,
  output logic       busy,
  output logic       grant_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state;
  logic [1:0]       grant;
  logic [1:0]       dest_q;
  logic [1:0]       scan_base;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic [CNT_W-1:0] burst_cnt;
  logic [3:0][1:0]  hd;
  logic [3:0]       elig;
  logic             found;
  logic             ok;
  logic             stay;
  logic             in_xfer;

  assign hd = {head_dest3, head_dest2, head_dest1, head_dest0};

  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++)
      elig[i] = en && !in_empty[i] && !out_full[hd[i]];
  end

  // First eligible input scanning upward from scan_base, wrapping mod 4.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = scan_base + 2'(k);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A head word bound elsewhere ends the burst so it gets re-arbitrated.
  assign ok         = !in_empty[grant] && !out_full[dest_q] && (hd[grant] == dest_q);
  assign in_xfer    = (state == XFER);
  assign stay       = ok && (burst_cnt < LAST_CNT) && en;
  assign pop        = (in_xfer && ok) ? (4'b0001 << grant) : 4'b0000;
  assign push       = (in_xfer && ok) ? (4'b0001 << dest_q) : 4'b0000;
  assign busy       = (state == GRANT) || in_xfer;
  assign grant_done = in_xfer && !stay;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      demux0    <= 2'd0;
      grant     <= 2'd0;
      dest_q    <= 2'd0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            grant     <= winner;
            demux0    <= winner;
            dest_q    <= hd[winner];
            burst_cnt <= '0;
          end
        end
        GRANT: state <= XFER;
        XFER: begin
          if (ok)
            burst_cnt <= burst_cnt + CNT_W'(1);
          if (!stay)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XBAR_SCHED_STRICT_PRIO_EN
  assign scan_base = 2'd0;
`else
  logic [1:0] rr_ptr;
  assign scan_base = rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= 2'd0;
    else if (grant_done)
      rr_ptr <= grant + 2'd1;
  end
`endif

endmodule
